db_multi_debouncer: RTL and testbench

Multi-channel, parametrised successor to the single-button debouncer in the DB block family. Each channel has:
- a configurable-depth synchroniser;
- a saturating stability counter;
- a debounced level output;
- registered one-cycle rise and fall pulses.

It sits between raw board inputs (buttons, switches) and control FSMs that need clean levels and edge events.

---
 rtl/db_pkg.sv | 14 +
 rtl/db_channel.sv | 89 ++++++++
 rtl/db_multi_debouncer.sv | 48 ++++
 tb/tb_db_multi_debouncer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// Shared constants, counter type and width helper for the DB debouncer family.
package db_pkg;

   localparam int DB_SYNC_STAGES_MIN = 2;
   localparam int DB_CTR_W_MAX       = 32;

   // Wide carrier for counter limits; channels slice it down to their own width.
   typedef logic [DB_CTR_W_MAX-1:0] db_ctr_t;

   function automatic int db_ctr_w(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/db_channel.sv
// One debounce channel: synchroniser, stability counter, level and edge pulses.
// Long-press detection is built only when DB_LONG_PRESS_EN is defined.
module db_channel
   import db_pkg::*;
#(
   parameter int LIMIT       = 4,
   parameter int SYNC_STAGES = 2,
   parameter bit RESET_LEVEL = 1'b0,
   parameter int LONG_LIMIT  = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic signal,
   output logic rise,
   output logic fall,
   output logic long_press
);

   localparam int      CW    = db_ctr_w(LIMIT);
   localparam db_ctr_t LIM_C = db_ctr_t'(LIMIT);
   localparam logic [CW-1:0] LIM = LIM_C[CW-1:0];

   if (LONG_LIMIT < 1) begin : g_chk_long_limit
      $error("db_channel: LONG_LIMIT must be >= 1");
   end

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic                   prev;
   logic                   signal_nxt;
   logic [CW-1:0]          cnt;

   assign s          = sync[SYNC_STAGES-1];
   // A level is accepted only once prev has been stable for LIMIT compares.
   assign signal_nxt = (cnt == LIM) ? prev : signal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync   <= {SYNC_STAGES{RESET_LEVEL}};
         prev   <= RESET_LEVEL;
         cnt    <= '0;
         signal <= RESET_LEVEL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], button};
         prev   <= s;
         if (s != prev)
            cnt <= '0;
         else if (cnt != LIM)
            cnt <= cnt + CW'(1);
         signal <= signal_nxt;
         rise   <= signal_nxt & ~signal;
         fall   <= ~signal_nxt & signal;
      end
   end

`ifdef DB_LONG_PRESS_EN
   localparam int      LW     = db_ctr_w(LONG_LIMIT);
   localparam db_ctr_t LLIM_C = db_ctr_t'(LONG_LIMIT);
   localparam logic [LW-1:0] LLIM = LLIM_C[LW-1:0];

   logic [LW-1:0] lp_cnt;
   logic [LW-1:0] lp_nxt;

   always_comb begin
      lp_nxt = lp_cnt;
      if (signal == RESET_LEVEL)
         lp_nxt = '0;
      else if (lp_cnt != LLIM)
         lp_nxt = lp_cnt + LW'(1);
   end

   // Pulse only on the edge into saturation, so a held press fires once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lp_cnt     <= '0;
         long_press <= 1'b0;
      end else begin
         lp_cnt     <= lp_nxt;
         long_press <= (lp_nxt == LLIM) && (lp_cnt != LLIM);
      end
   end
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: rtl/db_multi_debouncer.sv
// Multi-channel debouncer: CHANNELS independent db_channel instances.
// Optional long-press pulses are enabled by defining DB_LONG_PRESS_EN.
module db_multi_debouncer
   import db_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int LIMIT       = 4,
   parameter int SYNC_STAGES = 2,
   parameter bit RESET_LEVEL = 1'b0,
   parameter int LONG_LIMIT  = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] button,
   output logic [CHANNELS-1:0] signal,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] long_press
);

   if (CHANNELS < 1) begin : g_chk_channels
      $error("db_multi_debouncer: CHANNELS must be >= 1");
   end
   if (LIMIT < 1) begin : g_chk_limit
      $error("db_multi_debouncer: LIMIT must be >= 1");
   end
   if (SYNC_STAGES < DB_SYNC_STAGES_MIN) begin : g_chk_sync
      $error("db_multi_debouncer: SYNC_STAGES below minimum");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      db_channel #(
         .LIMIT       (LIMIT),
         .SYNC_STAGES (SYNC_STAGES),
         .RESET_LEVEL (RESET_LEVEL),
         .LONG_LIMIT  (LONG_LIMIT)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .button     (button[i]),
         .signal     (signal[i]),
         .rise       (rise[i]),
         .fall       (fall[i]),
         .long_press (long_press[i])
      );
   end

endmodule

// File: tb/tb_db_multi_debouncer.sv
// Directed bench for db_multi_debouncer: expected level changes are queued at
// drive time with their due cycle and retired against the outputs every cycle.
module tb_db_multi_debouncer;

   localparam int CH  = 4;
   localparam int LIM = 4;
   localparam int SS  = 2;
   localparam int LL  = 16;
   // Edges from the drive point (between edges) to the visible level change.
   localparam int DUE = SS + LIM + 1 + 1;
`ifdef DB_LONG_PRESS_EN
   localparam bit LP_ON = 1'b1;
`else
   localparam bit LP_ON = 1'b0;
`endif

   typedef struct {
      int due;
      int ch;
      bit lvl;
   } ev_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [CH-1:0] button = '0;
   logic [CH-1:0] signal, rise, fall, long_press;

   ev_t           q[$];
   logic [CH-1:0] exp_sig  = '0;
   logic [CH-1:0] exp_rise = '0;
   logic [CH-1:0] exp_fall = '0;
   logic [CH-1:0] exp_lp   = '0;
   int            hcnt[CH] = '{default: 0};
   int            ecnt  = 0;
   int            total = 0;
   int            bad   = 0;

   db_multi_debouncer #(
      .CHANNELS    (CH),
      .LIMIT       (LIM),
      .SYNC_STAGES (SS),
      .RESET_LEVEL (1'b0),
      .LONG_LIMIT  (LL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .button     (button),
      .signal     (signal),
      .rise       (rise),
      .fall       (fall),
      .long_press (long_press)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic compare(input string tag);
      total++;
      assert (signal === exp_sig) else begin
         bad++;
         $error("FAIL %s signal got=%b want=%b cyc=%0d", tag, signal, exp_sig, ecnt);
      end
      total++;
      assert (rise === exp_rise) else begin
         bad++;
         $error("FAIL %s rise got=%b want=%b cyc=%0d", tag, rise, exp_rise, ecnt);
      end
      total++;
      assert (fall === exp_fall) else begin
         bad++;
         $error("FAIL %s fall got=%b want=%b cyc=%0d", tag, fall, exp_fall, ecnt);
      end
      total++;
      assert (long_press === exp_lp) else begin
         bad++;
         $error("FAIL %s long_press got=%b want=%b cyc=%0d", tag, long_press, exp_lp, ecnt);
      end
   endtask

   // Retire events due this cycle and derive pulses / long-press expectation.
   task automatic model_step();
      exp_rise = '0;
      exp_fall = '0;
      exp_lp   = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].due == ecnt) begin
            if (q[i].lvl && !exp_sig[q[i].ch]) exp_rise[q[i].ch] = 1'b1;
            if (!q[i].lvl && exp_sig[q[i].ch]) exp_fall[q[i].ch] = 1'b1;
            exp_sig[q[i].ch] = q[i].lvl;
            q.delete(i);
         end
      end
      for (int c = 0; c < CH; c++) begin
         if (exp_sig[c]) begin
            if (hcnt[c] < LL + 2) hcnt[c]++;
         end else begin
            hcnt[c] = 0;
         end
         exp_lp[c] = LP_ON && (hcnt[c] == LL + 1);
      end
   endtask

   task automatic tick(input int n, input string tag);
      repeat (n) begin
         @(negedge clk);
         model_step();
         compare(tag);
      end
   endtask

   task automatic drive(input int ch, input bit val, input bit push);
      button[ch] = val;
      if (push) q.push_back('{ecnt + DUE, ch, val});
   endtask

   initial begin
      tick(3, "reset");
      rst_n = 1'b1;
      tick(10, "idle");

      // clean press and release on ch0
      drive(0, 1'b1, 1'b1);
      tick(20, "press0");
      drive(0, 1'b0, 1'b1);
      tick(12, "release0");

      // bounce on ch1, only the final level is accepted
      drive(1, 1'b1, 1'b0); tick(2, "bounce1");
      drive(1, 1'b0, 1'b0); tick(2, "bounce1");
      drive(1, 1'b1, 1'b0); tick(2, "bounce1");
      drive(1, 1'b0, 1'b0); tick(2, "bounce1");
      drive(1, 1'b1, 1'b1); tick(15, "settle1");

      // short glitch on ch2 is rejected
      drive(2, 1'b1, 1'b0); tick(3, "glitch2");
      drive(2, 1'b0, 1'b0); tick(12, "glitch2");

      // simultaneous press ch0 / release ch1
      drive(0, 1'b1, 1'b1);
      drive(1, 1'b0, 1'b1);
      tick(12, "simul");

      // async reset while ch3 is counting (count == 2)
      drive(3, 1'b1, 1'b0);
      tick(5, "pre_rst");
      rst_n = 1'b0;
      #1;
      q.delete();
      exp_sig  = '0;
      exp_rise = '0;
      exp_fall = '0;
      exp_lp   = '0;
      for (int c = 0; c < CH; c++) hcnt[c] = 0;
      compare("async_rst");
      tick(3, "in_rst");
      rst_n = 1'b1;
      drive(0, 1'b1, 1'b1);
      drive(3, 1'b1, 1'b1);
      tick(12, "post_rst");

      // long hold then short re-press
      drive(0, 1'b0, 1'b1);
      drive(3, 1'b0, 1'b1);
      tick(12, "release_all");
      drive(0, 1'b1, 1'b1);
      tick(40, "long_hold");
      drive(0, 1'b0, 1'b1);
      tick(12, "long_rel");
      drive(0, 1'b1, 1'b1);
      tick(10, "short_hold");
      drive(0, 1'b0, 1'b1);
      tick(15, "short_rel");

      total++;
      assert (q.size() == 0) else begin
         bad++;
         $error("FAIL pending_events got=%0d want=0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
